interface_output: RTL and testbench
===================================

// Module: interface_output
// PURPOSE
// - Back end of the CORDIC datapath; mirror of the input interface. Takes the core's per-sample result,
//   undoes the ±90 deg range reduction (flip) and buffers results in a FIFO with a valid/ready port.
// - Rotation mode (arctan_en=0) outputs cos/sin of the original angle; arctan mode passes the angle through.
// PARAMETERS
// - DATA_WIDTH   16  width of x/y/degree words; x/y are signed Q7.8, degree is signed integer degrees
// - FIFO_DEPTH   4   result buffer entries; power of 2, >=2
// - LEVEL_WIDTH  3   width of fifo_level; equals clog2(FIFO_DEPTH)+1
// PORTS
// - clk                      in   1   single clock; all state updates on rising edge
// - rst_n                    in   1   synchronous reset, active-low
// - x_out                    in   16  core X result, signed Q7.8 (cos of reduced angle, gain-compensated)
// - y_out                    in   16  core Y result, signed Q7.8 (sin of reduced angle)
// - degree_out               in   16  signed: reduced angle (rotation) or computed angle (arctan)
// - flip_out                 in   1   range-reduction flag carried alongside the sample
// - arctan_en_out            in   1   mode tag carried alongside the sample
// - valid_out                in   1   core result valid; no backpressure toward the core
// - ready_out_interface      in   1   downstream may accept this cycle
// - cos_out_interface        out  16  signed Q7.8 cos(theta); 0 in arctan mode
// - sin_out_interface        out  16  signed Q7.8 sin(theta); 0 in arctan mode
// - degree_out_interface     out  16  signed degrees: restored theta (rotation) or atan result
// - arctan_en_out_interface  out  1   mode of the presented sample
// - valid_out_interface      out  1   FIFO head valid
// - overflow_out_interface   out  1   sticky: a sample was dropped because the FIFO was full
// - fifo_level               out  3   number of occupied FIFO entries
// BEHAVIOUR
// - Reset (rst_n=0 at an edge): stage reg invalid, FIFO emptied, all outputs 0, overflow cleared.
//   A sample in flight when reset is applied is lost.
// - Stage 1 (registered, 1 cycle): post-process the sample captured when valid_out=1.
//   - Rotation, flip=0: cos=x, sin=y, deg=degree_out.
//   - Rotation, flip=1, degree_out>=0 (theta>90): cos=-y, sin=x, deg=degree_out+90.
//   - Rotation, flip=1, degree_out<0 (theta<-90): cos=y, sin=-x, deg=degree_out-90.
//   - Arctan mode: cos=sin=0, deg=degree_out; the flip flag is ignored.
//   - Negation is two's complement at 16 bits; the -32768 case is set by the macro below.
//   - Degree add/sub is 16-bit signed; restored range is [-180,180], no overflow possible.
// - Stage 2: FIFO, show-ahead. Its head drives the *_interface outputs directly (not registered again).
//   - Write when stage 1 is valid; read when valid_out_interface && ready_out_interface.
//   - Latency: valid_out at edge N, FIFO empty -> valid_out_interface=1 after edge N+2.
//   - Full with no read: incoming sample dropped, overflow set, stored entries untouched.
//   - Full with a read in the same cycle: write accepted, level unchanged, no overflow.
//   - Empty: valid_out_interface=0; data outputs hold the last popped values (0 after reset).
//   - Read/write pointers wrap modulo FIFO_DEPTH; fifo_level is 0..FIFO_DEPTH.
//   - Head outputs hold stable while valid_out_interface=1 and ready_out_interface=0.
// - overflow_out_interface is cleared only by reset.
// CONFIGURATION
// - INTERFACE_OUTPUT_SAT_EN defined: negating 16'sh8000 gives 16'sh7FFF (saturate).
// - INTERFACE_OUTPUT_SAT_EN undefined: negation wraps, so -(16'sh8000) = 16'sh8000.
// - All other behaviour is identical with or without the macro.
// TESTING
// - Rotation, flip=0: x=0x00DE, y=0x0080, deg=30 -> cos=0x00DE, sin=0x0080, deg=30.
// - Rotation, flip=1: x=0x00DE, y=0x0080, deg=30 (theta=120) -> cos=0xFF80, sin=0x00DE, deg=120.
// - Rotation, flip=1: x=0x00DE, y=0xFF80, deg=-30 (theta=-120) -> cos=0xFF80, sin=0xFF22, deg=-120.
// - Arctan mode, flip=1: deg=45, x=0x0100 -> cos=0, sin=0, deg=45, arctan_en_out_interface=1.
// - ready=0, 6 back-to-back samples -> level reaches 4, overflow=1, first 4 delivered in order once ready=1.
// - rst_n low mid-burst -> next cycle level=0, valid=0, overflow=0.
// - Full FIFO with ready=1 and a new sample -> level stays 4, no overflow.
// - y=0x8000, flip=1, deg>=0 -> cos=0x7FFF with INTERFACE_OUTPUT_SAT_EN, 0x8000 without.

Source files
------------

// File: rtl/interface_output.sv
// -----------------------------------------------------------------------------
// interface_output
// Back end of the CORDIC datapath. It takes each result from the core and
// undoes the +/-90 degree range reduction, then buffers the result in a
// show-ahead FIFO whose head drives the valid/ready output port.
//
// Configuration macro: INTERFACE_OUTPUT_SAT_EN
//   defined   -> negating the most negative word saturates to the most positive
//   undefined -> negation wraps (two's complement)
// -----------------------------------------------------------------------------
module interface_output #(
  parameter int DATA_WIDTH  = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int LEVEL_WIDTH = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_WIDTH-1:0]  x_out,
  input  logic [DATA_WIDTH-1:0]  y_out,
  input  logic [DATA_WIDTH-1:0]  degree_out,
  input  logic                   flip_out,
  input  logic                   arctan_en_out,
  input  logic                   valid_out,
  input  logic                   ready_out_interface,
  output logic [DATA_WIDTH-1:0]  cos_out_interface,
  output logic [DATA_WIDTH-1:0]  sin_out_interface,
  output logic [DATA_WIDTH-1:0]  degree_out_interface,
  output logic                   arctan_en_out_interface,
  output logic                   valid_out_interface,
  output logic                   overflow_out_interface,
  output logic [LEVEL_WIDTH-1:0] fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [DATA_WIDTH-1:0]  ZERO_W  = {DATA_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0]  ONE_W   = DATA_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0]  DEG_90  = DATA_WIDTH'(90);
  localparam logic [LEVEL_WIDTH-1:0] LVL_ONE = LEVEL_WIDTH'(1);
  localparam logic [LEVEL_WIDTH-1:0] LVL_MAX = LEVEL_WIDTH'(FIFO_DEPTH);
  localparam logic [LEVEL_WIDTH-1:0] LVL_0   = {LEVEL_WIDTH{1'b0}};
  localparam logic [PTR_W-1:0]       PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W-1:0]       PTR_0   = {PTR_W{1'b0}};

`ifdef INTERFACE_OUTPUT_SAT_EN
  localparam logic [DATA_WIDTH-1:0] MIN_W = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] MAX_W = {1'b0, {(DATA_WIDTH-1){1'b1}}};
`endif

  // Two's complement negation; the most negative value is the only special case.
  function automatic logic [DATA_WIDTH-1:0] neg_fn(input logic [DATA_WIDTH-1:0] v);
    logic [DATA_WIDTH-1:0] r;
`ifdef INTERFACE_OUTPUT_SAT_EN
    if (v == MIN_W) begin
      r = MAX_W;
    end else begin
      r = (~v) + ONE_W;
    end
`else
    r = (~v) + ONE_W;
`endif
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Stage 1: range-reduction undo
  // ---------------------------------------------------------------------------
  logic                  s1_valid_q, s1_valid_d;
  logic [DATA_WIDTH-1:0] s1_cos_q,   s1_cos_d;
  logic [DATA_WIDTH-1:0] s1_sin_q,   s1_sin_d;
  logic [DATA_WIDTH-1:0] s1_deg_q,   s1_deg_d;
  logic                  s1_atan_q,  s1_atan_d;

  // Post-process the incoming core sample; the angle sign tells which side was folded.
  always_comb begin
    s1_valid_d = valid_out;
    s1_cos_d   = s1_cos_q;
    s1_sin_d   = s1_sin_q;
    s1_deg_d   = s1_deg_q;
    s1_atan_d  = s1_atan_q;
    if (valid_out) begin
      s1_atan_d = arctan_en_out;
      if (arctan_en_out) begin
        s1_cos_d = ZERO_W;
        s1_sin_d = ZERO_W;
        s1_deg_d = degree_out;
      end else if (!flip_out) begin
        s1_cos_d = x_out;
        s1_sin_d = y_out;
        s1_deg_d = degree_out;
      end else if (!degree_out[DATA_WIDTH-1]) begin
        s1_cos_d = neg_fn(y_out);
        s1_sin_d = x_out;
        s1_deg_d = degree_out + DEG_90;
      end else begin
        s1_cos_d = y_out;
        s1_sin_d = neg_fn(x_out);
        s1_deg_d = degree_out - DEG_90;
      end
    end else begin
      s1_atan_d = s1_atan_q;
    end
  end

  // Stage 1 register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_cos_q   <= ZERO_W;
      s1_sin_q   <= ZERO_W;
      s1_deg_q   <= ZERO_W;
      s1_atan_q  <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_cos_q   <= s1_cos_d;
      s1_sin_q   <= s1_sin_d;
      s1_deg_q   <= s1_deg_d;
      s1_atan_q  <= s1_atan_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: show-ahead FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0]  mem_cos_q  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]  mem_cos_d  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]  mem_sin_q  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]  mem_sin_d  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]  mem_deg_q  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]  mem_deg_d  [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]  mem_atan_q, mem_atan_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [LEVEL_WIDTH-1:0] level_q,  level_d;
  logic                   ovf_q,    ovf_d;
  // Last popped values, shown while the FIFO is empty.
  logic [DATA_WIDTH-1:0]  last_cos_q,  last_cos_d;
  logic [DATA_WIDTH-1:0]  last_sin_q,  last_sin_d;
  logic [DATA_WIDTH-1:0]  last_deg_q,  last_deg_d;
  logic                   last_atan_q, last_atan_d;

  logic not_empty_s, full_s, rd_en_s, wr_en_s;

  // FIFO control: a read frees a slot in the same cycle, so a full FIFO still accepts on a read.
  always_comb begin
    not_empty_s = (level_q != LVL_0);
    full_s      = (level_q == LVL_MAX);
    rd_en_s     = not_empty_s && ready_out_interface;
    wr_en_s     = s1_valid_q && (!full_s || rd_en_s);

    mem_cos_d   = mem_cos_q;
    mem_sin_d   = mem_sin_q;
    mem_deg_d   = mem_deg_q;
    mem_atan_d  = mem_atan_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    ovf_d       = ovf_q;
    last_cos_d  = last_cos_q;
    last_sin_d  = last_sin_q;
    last_deg_d  = last_deg_q;
    last_atan_d = last_atan_q;

    if (wr_en_s) begin
      mem_cos_d[wr_ptr_q]  = s1_cos_q;
      mem_sin_d[wr_ptr_q]  = s1_sin_q;
      mem_deg_d[wr_ptr_q]  = s1_deg_q;
      mem_atan_d[wr_ptr_q] = s1_atan_q;
      wr_ptr_d             = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (rd_en_s) begin
      last_cos_d  = mem_cos_q[rd_ptr_q];
      last_sin_d  = mem_sin_q[rd_ptr_q];
      last_deg_d  = mem_deg_q[rd_ptr_q];
      last_atan_d = mem_atan_q[rd_ptr_q];
      rd_ptr_d    = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    if (wr_en_s && !rd_en_s) begin
      level_d = level_q + LVL_ONE;
    end else if (rd_en_s && !wr_en_s) begin
      level_d = level_q - LVL_ONE;
    end else begin
      level_d = level_q;
    end

    if (s1_valid_q && !wr_en_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // FIFO state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_cos_q[i] <= ZERO_W;
        mem_sin_q[i] <= ZERO_W;
        mem_deg_q[i] <= ZERO_W;
      end
      mem_atan_q  <= {FIFO_DEPTH{1'b0}};
      wr_ptr_q    <= PTR_0;
      rd_ptr_q    <= PTR_0;
      level_q     <= LVL_0;
      ovf_q       <= 1'b0;
      last_cos_q  <= ZERO_W;
      last_sin_q  <= ZERO_W;
      last_deg_q  <= ZERO_W;
      last_atan_q <= 1'b0;
    end else begin
      mem_cos_q   <= mem_cos_d;
      mem_sin_q   <= mem_sin_d;
      mem_deg_q   <= mem_deg_d;
      mem_atan_q  <= mem_atan_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      ovf_q       <= ovf_d;
      last_cos_q  <= last_cos_d;
      last_sin_q  <= last_sin_d;
      last_deg_q  <= last_deg_d;
      last_atan_q <= last_atan_d;
    end
  end

  // Output select: FIFO head when occupied, otherwise the last popped sample.
  always_comb begin
    if (not_empty_s) begin
      cos_out_interface       = mem_cos_q[rd_ptr_q];
      sin_out_interface       = mem_sin_q[rd_ptr_q];
      degree_out_interface    = mem_deg_q[rd_ptr_q];
      arctan_en_out_interface = mem_atan_q[rd_ptr_q];
    end else begin
      cos_out_interface       = last_cos_q;
      sin_out_interface       = last_sin_q;
      degree_out_interface    = last_deg_q;
      arctan_en_out_interface = last_atan_q;
    end
    valid_out_interface    = not_empty_s;
    overflow_out_interface = ovf_q;
    fifo_level             = level_q;
  end

endmodule

// File: tb/tb_interface_output.sv
// -----------------------------------------------------------------------------
// tb_interface_output: directed vectors with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_interface_output;

  logic        clk;
  logic        rst_n;
  logic [15:0] x_out, y_out, degree_out;
  logic        flip_out, arctan_en_out, valid_out, ready_out_interface;
  logic [15:0] cos_out_interface, sin_out_interface, degree_out_interface;
  logic        arctan_en_out_interface, valid_out_interface, overflow_out_interface;
  logic [2:0]  fifo_level;

  int n_chk  = 0;
  int n_fail = 0;

  interface_output dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .x_out                   (x_out),
    .y_out                   (y_out),
    .degree_out              (degree_out),
    .flip_out                (flip_out),
    .arctan_en_out           (arctan_en_out),
    .valid_out               (valid_out),
    .ready_out_interface     (ready_out_interface),
    .cos_out_interface       (cos_out_interface),
    .sin_out_interface       (sin_out_interface),
    .degree_out_interface    (degree_out_interface),
    .arctan_en_out_interface (arctan_en_out_interface),
    .valid_out_interface     (valid_out_interface),
    .overflow_out_interface  (overflow_out_interface),
    .fifo_level              (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] x, input logic [15:0] y, input logic [15:0] d,
                       input logic f, input logic a);
    x_out = x; y_out = y; degree_out = d; flip_out = f; arctan_en_out = a; valid_out = 1'b1;
  endtask

  // Single sample through an empty FIFO with ready=1; checks latency, head, pop and hold.
  task automatic one_sample(input string tag, input logic [15:0] x, input logic [15:0] y,
                            input logic [15:0] d, input logic f, input logic a,
                            input logic [15:0] ec, input logic [15:0] es,
                            input logic [15:0] ed, input logic ea);
    tick();
    drive(x, y, d, f, a);
    tick();
    valid_out = 1'b0;
    chk({tag, "_lat1"}, {31'd0, valid_out_interface}, 32'd0);
    tick();
    chk({tag, "_valid"}, {31'd0, valid_out_interface}, 32'd1);
    chk({tag, "_cos"},   {16'd0, cos_out_interface},    {16'd0, ec});
    chk({tag, "_sin"},   {16'd0, sin_out_interface},    {16'd0, es});
    chk({tag, "_deg"},   {16'd0, degree_out_interface}, {16'd0, ed});
    chk({tag, "_atan"},  {31'd0, arctan_en_out_interface}, {31'd0, ea});
    tick();
    chk({tag, "_empty"}, {31'd0, valid_out_interface}, 32'd0);
    chk({tag, "_hold"},  {16'd0, cos_out_interface},  {16'd0, ec});
  endtask

  logic [15:0] sat_exp;

  initial begin
    rst_n = 1'b0; valid_out = 1'b0; ready_out_interface = 1'b0;
    x_out = 16'h0000; y_out = 16'h0000; degree_out = 16'h0000;
    flip_out = 1'b0; arctan_en_out = 1'b0;
    tick(); tick();
    chk("rst_level", {29'd0, fifo_level}, 32'd0);
    chk("rst_valid", {31'd0, valid_out_interface}, 32'd0);
    chk("rst_ovf",   {31'd0, overflow_out_interface}, 32'd0);
    chk("rst_cos",   {16'd0, cos_out_interface}, 32'd0);
    chk("rst_deg",   {16'd0, degree_out_interface}, 32'd0);
    rst_n = 1'b1;
    ready_out_interface = 1'b1;

    one_sample("rot_nf",  16'h00DE, 16'h0080, 16'd30,  1'b0, 1'b0, 16'h00DE, 16'h0080, 16'd30,  1'b0);
    one_sample("rot_p",   16'h00DE, 16'h0080, 16'd30,  1'b1, 1'b0, 16'hFF80, 16'h00DE, 16'd120, 1'b0);
    one_sample("rot_n",   16'h00DE, 16'hFF80, 16'hFFE2, 1'b1, 1'b0, 16'hFF80, 16'hFF22, 16'hFF88, 1'b0);
    one_sample("atan",    16'h0100, 16'h0040, 16'd45,  1'b1, 1'b1, 16'h0000, 16'h0000, 16'd45,  1'b1);
    one_sample("deg0",    16'h0100, 16'h0000, 16'd0,   1'b1, 1'b0, 16'h0000, 16'h0100, 16'd90,  1'b0);
    one_sample("degm90",  16'h0000, 16'h0100, 16'hFFA6, 1'b1, 1'b0, 16'h0100, 16'h0000, 16'hFF4C, 1'b0);
`ifdef INTERFACE_OUTPUT_SAT_EN
    sat_exp = 16'h7FFF;
`else
    sat_exp = 16'h8000;
`endif
    one_sample("neg_min", 16'h0010, 16'h8000, 16'd10,  1'b1, 1'b0, sat_exp, 16'h0010, 16'd100, 1'b0);

    // Overflow: six back-to-back samples into a stalled output.
    ready_out_interface = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      drive(16'(i), 16'h0000, 16'd0, 1'b0, 1'b0);
      tick();
    end
    valid_out = 1'b0;
    tick(); tick(); tick();
    chk("ovf_level", {29'd0, fifo_level}, 32'd4);
    chk("ovf_flag",  {31'd0, overflow_out_interface}, 32'd1);
    chk("ovf_stall", {16'd0, cos_out_interface}, 32'd1);
    ready_out_interface = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk("ovf_order", {16'd0, cos_out_interface}, 32'(k));
      tick();
    end
    chk("ovf_drain", {31'd0, valid_out_interface}, 32'd0);
    chk("ovf_sticky", {31'd0, overflow_out_interface}, 32'd1);

    // Reset in the middle of a burst.
    ready_out_interface = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      drive(16'h0020 + 16'(i), 16'h0000, 16'd0, 1'b0, 1'b0);
      tick();
    end
    rst_n = 1'b0;
    tick();
    valid_out = 1'b0;
    chk("mrst_level", {29'd0, fifo_level}, 32'd0);
    chk("mrst_valid", {31'd0, valid_out_interface}, 32'd0);
    chk("mrst_ovf",   {31'd0, overflow_out_interface}, 32'd0);
    chk("mrst_cos",   {16'd0, cos_out_interface}, 32'd0);
    rst_n = 1'b1;
    tick(); tick(); tick();
    chk("mrst_lost",  {29'd0, fifo_level}, 32'd0);

    // Full FIFO with a simultaneous read and write.
    for (int i = 1; i <= 4; i++) begin
      drive(16'h0010 + 16'(i), 16'h0000, 16'd0, 1'b0, 1'b0);
      tick();
    end
    valid_out = 1'b0;
    tick(); tick();
    chk("frw_full", {29'd0, fifo_level}, 32'd4);
    drive(16'h0015, 16'h0000, 16'd0, 1'b0, 1'b0);
    tick();
    valid_out = 1'b0;
    ready_out_interface = 1'b1;
    tick();
    ready_out_interface = 1'b0;
    chk("frw_level", {29'd0, fifo_level}, 32'd4);
    chk("frw_ovf",   {31'd0, overflow_out_interface}, 32'd0);
    chk("frw_head",  {16'd0, cos_out_interface}, 32'h12);
    ready_out_interface = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      chk("frw_order", {16'd0, cos_out_interface}, 32'h10 + 32'(k));
      tick();
    end
    chk("frw_empty", {29'd0, fifo_level}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
